uart_fifo_avalon: RTL and testbench
===================================

UART_FIFO_AVALON -- requirements
Module: uart_fifo_avalon

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: frame data width, legal 5..8.
REQ-002 SHALL have parameter TX_DEPTH, default 16: TX FIFO entries, power of 2, at least 2.
REQ-003 SHALL have parameter RX_DEPTH, default 16: RX FIFO entries, power of 2, at least 2.
REQ-004 SHALL have parameter CLKS_PER_BIT, default 434: reset value of BAUD.
REQ-005 SHALL have ports clock (in, 1, clock) and resetn (in, 1, reset: synchronous, active-low).
REQ-006 SHALL have ports address (in, 2, word address), chipselect (in, 1), read (in, 1), write (in, 1), writedata (in, 32), readdata (out, 32), waitrequest (out, 1, tied 0).
REQ-007 SHALL have ports TX_export (out, 1, serial out), RX_export (in, 1, asynchronous serial in) and irq (out, 1, level interrupt).

Function
REQ-008 SHALL qualify every access with chipselect; rd = chipselect&read, wr = chipselect&write.
REQ-009 SHALL drive readdata combinationally in the access cycle, and drive 0 when rd=0.
REQ-010 SHALL implement addr 0 STATUS, read-only: bit0 rx_nonempty, bit1 tx_idle (TX FIFO empty and shifter idle), bit2 tx_full, bit3 rx_full, bit4 rx_overrun, bit5 framing_err, bit6 tx_overflow; all other bits 0.
REQ-011 SHALL clear each of STATUS bits 4..6 when 1 is written to that bit (W1C); writes to other STATUS bits SHALL be ignored.
REQ-012 SHALL implement addr 1 DATA: rd returns zero-extended RX FIFO head and pops it in the same cycle; rd when RX empty returns 0 with no pop.
REQ-013 SHALL push writedata[DATA_BITS-1:0] into the TX FIFO on a DATA write; a write when TX is full SHALL be dropped and set tx_overflow.
REQ-014 SHALL implement addr 2 BAUD, bits[15:0] R/W, as clocks per bit; values below 4 SHALL be treated as 4.
REQ-015 SHALL implement addr 3 CTRL, R/W: bit0 tx_en, bit1 rx_en, bit2 loopback, bit3 ie_rx, bit4 ie_tx.
REQ-016 SHALL drive irq = (ie_rx & rx_nonempty) | (ie_tx & tx_idle), combinational from registered state.
REQ-017 SHALL use a TX FSM with states IDLE, START, DATA, STOP, one bit period per START/STOP state and DATA_BITS periods in DATA, LSB first.
REQ-018 SHALL, in IDLE with tx_en=1 and the TX FIFO non-empty, pop the FIFO, latch BAUD, and enter START on the next cycle; TX_export SHALL be 1 in IDLE.
REQ-019 SHALL, at the end of STOP, re-enter START directly when the FIFO is non-empty and tx_en=1, with no idle gap; otherwise it SHALL return to IDLE.
REQ-020 SHALL, when tx_en is cleared mid-frame, complete the current frame and then halt in IDLE.
REQ-021 SHALL pass RX_export (or TX_export when loopback=1) through a 2-flop synchroniser; in loopback, TX_export SHALL still toggle.
REQ-022 SHALL use an RX FSM with states IDLE, START, DATA, STOP; a falling edge of the synchronised line in IDLE with rx_en=1 latches BAUD and enters START.
REQ-023 SHALL sample the line at BAUD/2 in START; if the line is high it SHALL return to IDLE (glitch reject), otherwise it SHALL sample each data bit and the stop bit at BAUD intervals.
REQ-024 SHALL push the byte when the stop bit is 1; when the stop bit is 0 it SHALL set framing_err, discard the byte, and return to IDLE.
REQ-025 SHALL, on a push to a full RX FIFO, drop the new byte, leave the FIFO unchanged, and set rx_overrun.
REQ-026 SHALL let a simultaneous push and pop on a FIFO both take effect with the count unchanged; this holds when full (push honoured because pop frees a slot) and when empty only for push.
REQ-027 SHALL, when a W1C clear and a set of the same sticky bit occur in the same cycle, leave the bit set.
REQ-028 SHALL apply a BAUD write mid-frame from the next frame only.

Reset
REQ-029 SHALL, while resetn=0 at a clock edge: empty both FIFOs, put both FSMs in IDLE, clear sticky bits, set BAUD=CLKS_PER_BIT, set CTRL=0x03, drive TX_export=1 and irq=0, and load synchroniser flops with 1.
REQ-030 SHALL, on reset mid-frame, abort the frame immediately with no partial push.

Structure
REQ-031 SHALL place register address constants, STATUS/CTRL bit indices, and the FSM state encodings in shared package uart_pkg.
REQ-032 SHALL instantiate one sub-module uart_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty) twice, once for TX and once for RX.

Verification
REQ-033 SHALL cover: BAUD=16, write DATA 0xA5 -> TX_export low 16 clk, then 1,0,1,0,0,1,0,1 at 16 clk each, stop high; tx_idle=1 after stop.
REQ-034 SHALL cover: loopback=1, write 0x3C, 0xC3 -> RX FIFO holds 2 bytes, reads return 0x3C then 0xC3, then rx_nonempty=0 and a further read returns 0.
REQ-035 SHALL cover: RX_DEPTH=4, inject 5 frames with no reads -> rx_full=1, rx_overrun=1, first 4 bytes read intact; writing STATUS 0x10 clears overrun.
REQ-036 SHALL cover: inject frame 0x55 with stop bit 0 -> framing_err=1 and FIFO unchanged; a 3-clk low glitch at BAUD=16 -> no frame.
REQ-037 SHALL cover: TX_DEPTH=2, write 3 bytes in consecutive cycles -> third accepted only if shifter popped first, otherwise tx_overflow=1; frames are back-to-back with no gap.
REQ-038 SHALL cover: assert resetn=0 mid-TX-frame -> TX_export=1 next cycle, STATUS=0x02, BAUD readback=CLKS_PER_BIT.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the Avalon UART: register map, bit indices, FSM states.
// Imported by the top and the FIFO.
package uart_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_RXNE   = 0;
  localparam int ST_TXIDLE = 1;
  localparam int ST_TXFULL = 2;
  localparam int ST_RXFULL = 3;
  localparam int ST_OVR    = 4;
  localparam int ST_FERR   = 5;
  localparam int ST_TXOVF  = 6;

  localparam int CT_TXEN = 0;
  localparam int CT_RXEN = 1;
  localparam int CT_LOOP = 2;
  localparam int CT_IERX = 3;
  localparam int CT_IETX = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_e;

  // Very short bit periods break the half-bit sampling point.
  function automatic logic [15:0] eff_baud(input logic [15:0] b);
    return (b < 16'd4) ? 16'd4 : b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push when full is honoured
// only if a pop frees a slot in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic             do_push, do_pop;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rp_q[AW-1:0]];

  always_comb begin
    wp_d = wp_q + {{AW{1'b0}}, do_push};
    rp_d = rp_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clock) begin
    if (resetn && do_push) begin
      mem_q[wp_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_fifo_avalon.sv
// Avalon-MM UART with TX/RX FIFOs, programmable baud, loopback,
// sticky error flags and a level interrupt.
module uart_fifo_avalon
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        TX_export,
  input  logic        RX_export,
  output logic        irq
);

  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

  logic rd, wr, w1c;
  logic [15:0] baud_q, baud_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic ovr_q, ovr_d, ferr_q, ferr_d, txovf_q, txovf_d;
  logic [31:0] status_w;
  logic unused_wdata;

  logic tx_push, tx_pop, tx_full, tx_empty, tx_idle;
  logic [DATA_BITS-1:0] tx_dout;
  logic rx_push, rx_pop, rx_full, rx_empty, ferr_set;
  logic [DATA_BITS-1:0] rx_dout;

  uart_state_e txs_q, txs_d;
  logic [15:0] txcnt_q, txcnt_d, txbaud_q, txbaud_d;
  logic [2:0]  txbit_q, txbit_d;
  logic [DATA_BITS-1:0] txsh_q, txsh_d;
  logic tx_q, tx_d, tx_last, tx_load;

  uart_state_e rxs_q, rxs_d;
  logic [15:0] rxcnt_q, rxcnt_d, rxbaud_q, rxbaud_d;
  logic [2:0]  rxbit_q, rxbit_d;
  logic [DATA_BITS-1:0] rxsh_q, rxsh_d;
  logic sync1_q, sync2_q, prev_q;
  logic rx_line, rx_fall, rx_half, rx_end;

  assign rd  = chipselect & read;
  assign wr  = chipselect & write;
  assign w1c = wr && (address == ADDR_STATUS);
  assign unused_wdata = ^writedata[31:16];

  assign tx_push = wr && (address == ADDR_DATA);
  assign rx_pop  = rd && (address == ADDR_DATA) && !rx_empty;
  assign tx_idle = tx_empty && (txs_q == S_IDLE);

  assign waitrequest = 1'b0;
  assign TX_export   = tx_q;
  assign irq = (ctrl_q[CT_IERX] & ~rx_empty) |
               (ctrl_q[CT_IETX] & tx_idle);

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock (clock),
    .resetn(resetn),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (writedata[DATA_BITS-1:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock (clock),
    .resetn(resetn),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rxsh_q),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    status_w = '0;
    status_w[ST_RXNE]   = ~rx_empty;
    status_w[ST_TXIDLE] = tx_idle;
    status_w[ST_TXFULL] = tx_full;
    status_w[ST_RXFULL] = rx_full;
    status_w[ST_OVR]    = ovr_q;
    status_w[ST_FERR]   = ferr_q;
    status_w[ST_TXOVF]  = txovf_q;
  end

  always_comb begin
    readdata = '0;
    if (rd) begin
      unique case (address)
        ADDR_STATUS: readdata = status_w;
        ADDR_DATA:   readdata[DATA_BITS-1:0] = rx_empty ? '0 : rx_dout;
        ADDR_BAUD:   readdata[15:0] = baud_q;
        ADDR_CTRL:   readdata[4:0]  = ctrl_q;
      endcase
    end
  end

  // A set in the same cycle as its W1C clear wins.
  always_comb begin
    baud_d  = (wr && address == ADDR_BAUD) ? writedata[15:0] : baud_q;
    ctrl_d  = (wr && address == ADDR_CTRL) ? writedata[4:0] : ctrl_q;
    ovr_d   = (ovr_q & ~(w1c & writedata[ST_OVR])) |
              (rx_push & rx_full & ~rx_pop);
    ferr_d  = (ferr_q & ~(w1c & writedata[ST_FERR])) | ferr_set;
    txovf_d = (txovf_q & ~(w1c & writedata[ST_TXOVF])) |
              (tx_push & tx_full & ~tx_pop);
  end

  always_comb begin
    txs_d    = txs_q;
    txcnt_d  = txcnt_q;
    txbit_d  = txbit_q;
    txsh_d   = txsh_q;
    txbaud_d = txbaud_q;
    tx_pop   = 1'b0;
    tx_load  = 1'b0;
    tx_last  = (txcnt_q == txbaud_q - 16'd1);
    unique case (txs_q)
      S_IDLE: tx_load = ctrl_q[CT_TXEN] & ~tx_empty;
      S_START: begin
        txcnt_d = txcnt_q + 16'd1;
        if (tx_last) begin
          txcnt_d = '0;
          txbit_d = '0;
          txs_d   = S_DATA;
        end
      end
      S_DATA: begin
        txcnt_d = txcnt_q + 16'd1;
        if (tx_last) begin
          txcnt_d = '0;
          txsh_d  = txsh_q >> 1;
          txbit_d = txbit_q + 3'd1;
          if (txbit_q == LAST) txs_d = S_STOP;
        end
      end
      S_STOP: begin
        txcnt_d = txcnt_q + 16'd1;
        if (tx_last) begin
          txcnt_d = '0;
          txs_d   = S_IDLE;
          tx_load = ctrl_q[CT_TXEN] & ~tx_empty;
        end
      end
      default: txs_d = S_IDLE;
    endcase
    if (tx_load) begin
      tx_pop   = 1'b1;
      txsh_d   = tx_dout;
      txbaud_d = eff_baud(baud_q);
      txcnt_d  = '0;
      txs_d    = S_START;
    end
    unique case (txs_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = txsh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign rx_line = sync2_q;
  assign rx_fall = prev_q & ~sync2_q;
  assign rx_half = (rxcnt_q == (rxbaud_q >> 1));
  assign rx_end  = (rxcnt_q == rxbaud_q - 16'd1);

  always_comb begin
    rxs_d    = rxs_q;
    rxcnt_d  = rxcnt_q;
    rxbit_d  = rxbit_q;
    rxsh_d   = rxsh_q;
    rxbaud_d = rxbaud_q;
    rx_push  = 1'b0;
    ferr_set = 1'b0;
    unique case (rxs_q)
      S_IDLE: begin
        if (ctrl_q[CT_RXEN] && rx_fall) begin
          rxbaud_d = eff_baud(baud_q);
          rxcnt_d  = '0;
          rxs_d    = S_START;
        end
      end
      S_START: begin
        rxcnt_d = rxcnt_q + 16'd1;
        if (rx_half) begin
          rxcnt_d = '0;
          rxbit_d = '0;
          rxs_d   = rx_line ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        rxcnt_d = rxcnt_q + 16'd1;
        if (rx_end) begin
          rxcnt_d = '0;
          rxsh_d  = {rx_line, rxsh_q[DATA_BITS-1:1]};
          rxbit_d = rxbit_q + 3'd1;
          if (rxbit_q == LAST) rxs_d = S_STOP;
        end
      end
      S_STOP: begin
        rxcnt_d = rxcnt_q + 16'd1;
        if (rx_end) begin
          rxcnt_d  = '0;
          rxs_d    = S_IDLE;
          rx_push  = rx_line;
          ferr_set = ~rx_line;
        end
      end
      default: rxs_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      baud_q   <= 16'(CLKS_PER_BIT);
      ctrl_q   <= 5'h03;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      txovf_q  <= 1'b0;
      txs_q    <= S_IDLE;
      txcnt_q  <= '0;
      txbit_q  <= '0;
      txsh_q   <= '0;
      txbaud_q <= 16'd4;
      tx_q     <= 1'b1;
      rxs_q    <= S_IDLE;
      rxcnt_q  <= '0;
      rxbit_q  <= '0;
      rxsh_q   <= '0;
      rxbaud_q <= 16'd4;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
    end else begin
      baud_q   <= baud_d;
      ctrl_q   <= ctrl_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      txovf_q  <= txovf_d;
      txs_q    <= txs_d;
      txcnt_q  <= txcnt_d;
      txbit_q  <= txbit_d;
      txsh_q   <= txsh_d;
      txbaud_q <= txbaud_d;
      tx_q     <= tx_d;
      rxs_q    <= rxs_d;
      rxcnt_q  <= rxcnt_d;
      rxbit_q  <= rxbit_d;
      rxsh_q   <= rxsh_d;
      rxbaud_q <= rxbaud_d;
      sync1_q  <= ctrl_q[CT_LOOP] ? tx_q : RX_export;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
    end
  end

endmodule

// File: tb/tb_uart_fifo_avalon.sv
// Directed bench for uart_fifo_avalon: register vector table plus
// hand-written TX, loopback, overrun, framing and reset sequences.
module tb_uart_fifo_avalon;

  localparam int CPB = 434;
  localparam logic [1:0] A_ST = 2'd0;
  localparam logic [1:0] A_DT = 2'd1;
  localparam logic [1:0] A_BD = 2'd2;
  localparam logic [1:0] A_CT = 2'd3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        TX_export;
  logic        RX_export = 1'b1;
  logic        irq;

  int ntests = 0;
  int nfail = 0;
  logic smp [160];

  typedef struct {
    logic        wr;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  always #5 clock = ~clock;

  uart_fifo_avalon #(
    .DATA_BITS(8), .TX_DEPTH(2), .RX_DEPTH(4), .CLKS_PER_BIT(CPB)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .waitrequest(waitrequest),
    .TX_export  (TX_export),
    .RX_export  (RX_export),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    #2 d = readdata;
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic [1:0] a,
                          input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_fall(input string name, input int maxw,
                           output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxw; i++) begin
      tick();
      if (TX_export === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " start"}, ok, 1'b1);
  endtask

  task automatic capture_rest(input int from);
    for (int i = from; i < 160; i++) begin
      tick();
      smp[i] = TX_export;
    end
  endtask

  // Each of start, 8 data and stop must hold for all 16 clocks.
  task automatic check_bits(input string name, input logic [7:0] b);
    logic e;
    int   n;
    for (int k = 0; k < 10; k++) begin
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      n = 0;
      for (int j = 0; j < 16; j++) if (smp[16*k+j] === e) n++;
      check($sformatf("%s bit%0d", name, k), n, 16);
    end
  endtask

  task automatic capture_frame(input string name, input logic [7:0] b,
                               input int maxw);
    logic ok;
    wait_fall(name, maxw, ok);
    if (ok) begin
      smp[0] = 1'b0;
      capture_rest(1);
      check_bits(name, b);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    for (int k = 0; k < 10; k++) begin
      RX_export = (k == 0) ? 1'b0 : (k == 9) ? stopb : b[k-1];
      repeat (16) tick();
    end
    RX_export = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v [12];
    logic ok;
    int   n;

    v[0]  = '{1'b0, A_ST, 32'h0,         32'h02};
    v[1]  = '{1'b0, A_BD, 32'h0,         32'(CPB)};
    v[2]  = '{1'b0, A_CT, 32'h0,         32'h03};
    v[3]  = '{1'b0, A_DT, 32'h0,         32'h00};
    v[4]  = '{1'b1, A_BD, 32'h0001_0010, 32'h0};
    v[5]  = '{1'b0, A_BD, 32'h0,         32'h10};
    v[6]  = '{1'b1, A_CT, 32'hFFFF_FFFF, 32'h0};
    v[7]  = '{1'b0, A_CT, 32'h0,         32'h1F};
    v[8]  = '{1'b1, A_ST, 32'hFF,        32'h0};
    v[9]  = '{1'b0, A_ST, 32'h0,         32'h02};
    v[10] = '{1'b1, A_BD, 32'h2,         32'h0};
    v[11] = '{1'b0, A_BD, 32'h0,         32'h02};

    tick();
    repeat (3) tick();
    check("rst_tx", TX_export, 1'b1);
    check("rst_irq", irq, 1'b0);
    resetn = 1'b1;
    tick();
    check("idle_rdata", readdata, 32'h0);
    check("waitreq", waitrequest, 1'b0);

    for (int i = 0; i < 12; i++) begin
      if (v[i].wr) bus_wr(v[i].a, v[i].d);
      else check_rd($sformatf("vec%0d", i), v[i].a, v[i].exp);
    end

    bus_wr(A_CT, 32'h13);
    check("irq_txidle", irq, 1'b1);
    bus_wr(A_CT, 32'h03);
    check("irq_off", irq, 1'b0);

    // BAUD=2 is clamped to 4 clocks per bit
    bus_wr(A_DT, 32'hFF);
    wait_fall("clamp", 5, ok);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (TX_export === 1'b0) n++;
    end
    check("baud_min4", n, 4);
    repeat (40) tick();

    bus_wr(A_BD, 32'd16);
    bus_wr(A_DT, 32'hA5);
    capture_frame("a5", 8'hA5, 5);
    repeat (2) tick();
    check_rd("a5_idle", A_ST, 32'h02);

    // three writes in consecutive cycles; shifter pops after the first
    chipselect = 1'b1; write = 1'b1; address = A_DT;
    writedata = 32'h11;
    tick();
    writedata = 32'h22;
    tick();
    smp[0] = TX_export;
    writedata = 32'h33;
    tick();
    smp[1] = TX_export;
    chipselect = 1'b0; write = 1'b0;
    capture_rest(2);
    check_bits("b2b0", 8'h11);
    capture_frame("b2b1", 8'h22, 1);
    capture_frame("b2b2", 8'h33, 1);
    repeat (2) tick();
    check_rd("b2b_status", A_ST, 32'h02);

    // same burst with TX halted: third write overflows
    bus_wr(A_CT, 32'h02);
    chipselect = 1'b1; write = 1'b1; address = A_DT;
    writedata = 32'h44;
    tick();
    writedata = 32'h55;
    tick();
    writedata = 32'h66;
    tick();
    chipselect = 1'b0; write = 1'b0;
    check_rd("ovf_status", A_ST, 32'h44);
    bus_wr(A_ST, 32'h40);
    check_rd("ovf_clr", A_ST, 32'h04);
    bus_wr(A_CT, 32'h03);
    capture_frame("ovf0", 8'h44, 5);
    capture_frame("ovf1", 8'h55, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (TX_export === 1'b0) n++;
    end
    check("ovf_no3rd", n, 0);
    check_rd("ovf_idle", A_ST, 32'h02);

    // loopback with rx interrupt enabled
    bus_wr(A_CT, 32'h0F);
    check("lb_irq0", irq, 1'b0);
    bus_wr(A_DT, 32'h3C);
    bus_wr(A_DT, 32'hC3);
    repeat (400) tick();
    check("lb_irq1", irq, 1'b1);
    check_rd("lb_status", A_ST, 32'h03);
    check_rd("lb_rd0", A_DT, 32'h3C);
    check_rd("lb_rd1", A_DT, 32'hC3);
    check_rd("lb_empty", A_ST, 32'h02);
    check_rd("lb_rd2", A_DT, 32'h00);
    check("lb_irq2", irq, 1'b0);

    // overrun with a 4-deep RX FIFO
    bus_wr(A_CT, 32'h02);
    for (int b = 1; b <= 5; b++) send_rx(8'(b), 1'b1);
    repeat (20) tick();
    check_rd("ovr_status", A_ST, 32'h1B);
    bus_wr(A_ST, 32'h10);
    check_rd("ovr_clr", A_ST, 32'h0B);
    for (int b = 1; b <= 4; b++)
      check_rd($sformatf("ovr_rd%0d", b), A_DT, 32'(b));
    check_rd("ovr_empty", A_ST, 32'h02);

    // framing error then glitch reject
    send_rx(8'h55, 1'b0);
    repeat (20) tick();
    check_rd("ferr_status", A_ST, 32'h22);
    check_rd("ferr_nodata", A_DT, 32'h00);
    bus_wr(A_ST, 32'h20);
    check_rd("ferr_clr", A_ST, 32'h02);
    RX_export = 1'b0;
    repeat (3) tick();
    RX_export = 1'b1;
    repeat (200) tick();
    check_rd("glitch_status", A_ST, 32'h02);
    check_rd("glitch_nodata", A_DT, 32'h00);

    // reset in the middle of a loopback frame
    bus_wr(A_CT, 32'h07);
    bus_wr(A_DT, 32'h00);
    wait_fall("rst", 5, ok);
    repeat (40) tick();
    resetn = 1'b0;
    tick();
    check("rst_mid_tx", TX_export, 1'b1);
    check("rst_mid_irq", irq, 1'b0);
    resetn = 1'b1;
    check_rd("rst_status", A_ST, 32'h02);
    check_rd("rst_baud", A_BD, 32'(CPB));
    check_rd("rst_ctrl", A_CT, 32'h03);
    repeat (200) tick();
    check_rd("rst_nopush", A_DT, 32'h00);
    check_rd("rst_status2", A_ST, 32'h02);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
